// File: rtl/ram_ctrl.sv
// Bus controller for a shared synchronous word RAM. It turns valid/ready load/store
// requests into cs/we/oe strobes, merges partial stores with the old word, and range-checks addresses.
module ram_ctrl #(
   parameter int MEM_WORDS = 21,
   parameter int AW        = 8,
   parameter int DW        = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [DW/8-1:0]   req_be,
   input  logic [DW-1:0]     req_wdata,
   output logic              resp_valid,
   output logic [DW-1:0]     resp_rdata,
   output logic              resp_err,
   output logic [AW-1:0]     ram_addr,
   inout  wire  [DW-1:0]     ram_data,
   output logic              ram_cs,
   output logic              ram_we,
   output logic              ram_oe
);

   localparam int NB = DW / 8;
   localparam logic [AW:0] MEM_LIMIT = (AW + 1)'(MEM_WORDS);

   typedef enum logic [2:0] {
      IDLE, RD, RD_CAP, WR, RMW_RD, RMW_CAP, RMW_WR, RESP
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [NB-1:0]     be_q, be_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [DW-1:0]     old_q, old_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [AW-1:0]     req_idx;
   logic              idx_oob;
   logic [DW-1:0]     merged;
   logic              bus_drive;
   logic              unused_addr_bits;

   assign req_idx          = req_addr[AW+1:2];
   assign idx_oob          = {1'b0, req_idx} >= MEM_LIMIT;
   assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

   // Partial-store merge: enabled lanes come from the request, the rest from the captured old word.
   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_merge
         assign merged[8*gi +: 8] = be_q[gi] ? wdata_q[8*gi +: 8] : old_q[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         old_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         old_q   <= old_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // resp_rdata/resp_err only change on edges that enter RESP, so they hold between responses.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      old_d   = old_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_idx;
               be_d    = req_be;
               wdata_d = req_wdata;
               if (idx_oob) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else if (!req_we) begin
                  state_d = RD;
               end else if (req_be == '1) begin
                  state_d = WR;
               end else if (req_be == '0) begin
                  state_d = RESP;
                  err_d   = 1'b0;
                  rdata_d = '0;
               end else begin
                  state_d = RMW_RD;
               end
            end
         end
         RD:      state_d = RD_CAP;
         RD_CAP: begin
            rdata_d = ram_data;
            err_d   = 1'b0;
            state_d = RESP;
         end
         WR, RMW_WR: begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = RESP;
         end
         RMW_RD:  state_d = RMW_CAP;
         RMW_CAP: begin
            old_d   = ram_data;
            state_d = RMW_WR;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes decode straight from the state flop so an async reset drops them at once.
   always_comb begin
      ram_cs    = 1'b0;
      ram_we    = 1'b0;
      ram_oe    = 1'b0;
      bus_drive = 1'b0;
      case (state_q)
         RD, RD_CAP, RMW_RD, RMW_CAP: begin
            ram_cs = 1'b1;
            ram_oe = 1'b1;
         end
         WR, RMW_WR: begin
            ram_cs    = 1'b1;
            ram_we    = 1'b1;
            bus_drive = 1'b1;
         end
         default: ;
      endcase
   end

   assign ram_data   = bus_drive ? ((state_q == RMW_WR) ? merged : wdata_q) : {DW{1'bz}};
   assign ram_addr   = addr_q;
   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Randomised scoreboard bench for ram_ctrl: a behavioural RAM on the bus, a word-array
// reference model fed at acceptance, and a monitor that checks every response and bus cycle.
module tb_ram_ctrl;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int MEM_WORDS = 21;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [3:0]  req_be = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [AW-1:0] ram_addr;
   wire  [31:0] ram_data;
   logic        ram_cs, ram_we, ram_oe;

   always #5 clk = ~clk;

   ram_ctrl #(.MEM_WORDS(MEM_WORDS), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .ram_addr(ram_addr), .ram_data(ram_data),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
   );

   // Synchronous RAM with a one-cycle registered read, driving the bus while cs&oe.
   logic [31:0] ram [0:255];
   logic [31:0] ram_rd_q = '0;
   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_we) ram[ram_addr] <= ram_data;
         else if (ram_oe) ram_rd_q <= ram[ram_addr];
      end
   end
   assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_rd_q : 32'hzzzz_zzzz;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] model [0:255];
   logic [31:0] exp_wr = '0;
   bit          no_cs = 1'b0;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          resp_count = 0;
   int          last_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Monitor: bus hygiene every cycle, and a scoreboard pop on every response.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("we_oe_exclusive", 32'(ram_we & ram_oe), 32'd0);
         if (no_cs) chk("no_ram_access", 32'(ram_cs), 32'd0);
         if (ram_cs && ram_oe) chk("oe_bus_owned_by_ram", ram_data, ram_rd_q);
         if (ram_cs && ram_we) chk("write_bus_data", ram_data, exp_wr);
         if (resp_valid) begin
            resp_count++;
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_resp: got resp_valid=1, required no response (cycle %0d)", cyc);
            end else begin
               mon_e = sb.pop_front();
               chk("resp_rdata", resp_rdata, mon_e.rdata);
               chk("resp_err", 32'(resp_err), 32'(mon_e.err));
               chk("resp_latency", 32'(cyc), 32'(mon_e.cyc));
               no_cs = 1'b0;
            end
         end
      end
   end

   // Issue one request; called and returning on a falling edge. The model is updated at acceptance.
   task automatic do_req(input bit we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input bit hold, input bit push);
      int          n;
      int          lat;
      int          idx;
      exp_t        e;
      logic [31:0] w;
      req_we    = we;
      req_addr  = addr;
      req_be    = be;
      req_wdata = wd;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got req_ready=0, required 1 within 100 cycles");
         req_valid = 1'b0;
         return;
      end
      last_acc = cyc + 1;
      idx = int'(addr[AW+1:2]);
      e.rdata = '0;
      e.err   = 1'b0;
      no_cs   = 1'b0;
      if (idx >= MEM_WORDS) begin
         e.err = 1'b1;
         lat   = 1;
         no_cs = 1'b1;
      end else if (!we) begin
         e.rdata = model[idx];
         lat     = 3;
      end else if (be == 4'hF) begin
         exp_wr = wd;
         lat    = 2;
      end else if (be == 4'h0) begin
         lat   = 1;
         no_cs = 1'b1;
      end else begin
         w = model[idx];
         for (int b = 0; b < 4; b++)
            if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
         exp_wr = w;
         lat    = 4;
      end
      e.cyc = last_acc + lat - 1;
      if (push) begin
         if (we && idx < MEM_WORDS && be != 4'h0) model[idx] = exp_wr;
         sb.push_back(e);
      end
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || !req_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0 || !req_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL idle_timeout: got %0d pending responses, required 0", sb.size());
      end
   endtask

   initial begin
      int a0, a1, c0;
      int w;
      int r;
      bit hold;
      logic [3:0] be;

      repeat (3) @(negedge clk);
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_resp_err", 32'(resp_err), 32'd0);
      chk("reset_resp_rdata", resp_rdata, 32'd0);
      chk("reset_ram_addr", 32'(ram_addr), 32'd0);
      chk("reset_strobes", 32'({ram_cs, ram_we, ram_oe}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Give every populated word a known value.
      for (int i = 0; i < MEM_WORDS; i++) do_req(1'b1, 32'(i * 4), 4'hF, $urandom, 1'b0, 1'b1);
      wait_idle();

      // Full store then load.
      do_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1);
      do_req(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b1);
      wait_idle();
      chk("load_deadbeef", resp_rdata, 32'hDEADBEEF);

      // Partial store with visible RMW strobe sequence.
      do_req(1'b1, 32'h08, 4'hF, 32'h11223344, 1'b0, 1'b1);
      do_req(1'b1, 32'h08, 4'b0010, 32'h0000AA00, 1'b0, 1'b1);
      chk("rmw_rd_strobes", 32'({ram_cs, ram_we, ram_oe}), 32'b101);
      @(negedge clk);
      chk("rmw_cap_strobes", 32'({ram_cs, ram_we, ram_oe}), 32'b101);
      @(negedge clk);
      chk("rmw_wr_strobes", 32'({ram_cs, ram_we, ram_oe}), 32'b110);
      do_req(1'b0, 32'h08, 4'h0, 32'h0, 1'b0, 1'b1);
      wait_idle();
      chk("load_merged", resp_rdata, 32'h1122AA44);

      // Range errors and an empty store.
      do_req(1'b0, 32'h54, 4'h0, 32'h0, 1'b0, 1'b1);
      do_req(1'b1, 32'h7C, 4'hF, 32'h12345678, 1'b0, 1'b1);
      do_req(1'b1, 32'h0C, 4'h0, 32'hFFFFFFFF, 1'b0, 1'b1);
      wait_idle();

      // Back-to-back loads with req_valid held high.
      c0 = resp_count;
      do_req(1'b0, 32'h04, 4'h0, 32'h0, 1'b1, 1'b1);
      a0 = last_acc;
      chk("busy_req_ready", 32'(req_ready), 32'd0);
      do_req(1'b0, 32'h08, 4'h0, 32'h0, 1'b1, 1'b1);
      a1 = last_acc;
      chk("load_spacing", 32'(a1 - a0), 32'd4);
      do_req(1'b0, 32'h0C, 4'h0, 32'h0, 1'b0, 1'b1);
      chk("load_spacing2", 32'(last_acc - a1), 32'd4);
      wait_idle();
      chk("held_resp_count", 32'(resp_count - c0), 32'd3);

      // Reset during RMW_CAP aborts the store with no response.
      c0 = resp_count;
      do_req(1'b1, 32'h14, 4'b0100, 32'h00550000, 1'b0, 1'b0);
      @(negedge clk);
      chk("abort_pre_strobes", 32'({ram_cs, ram_we, ram_oe}), 32'b101);
      rst_n = 1'b0;
      #1;
      chk("abort_strobes", 32'({ram_cs, ram_we, ram_oe}), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_no_resp", 32'(resp_count - c0), 32'd0);
      do_req(1'b0, 32'h14, 4'h0, 32'h0, 1'b0, 1'b1);
      wait_idle();

      // Randomised mix of loads, full/partial/empty stores and out-of-range addresses.
      for (int k = 0; k < 80; k++) begin
         w = $urandom_range(0, 23);
         r = $urandom_range(0, 3);
         be = (r == 0) ? 4'hF : (r == 1) ? 4'h0 : 4'($urandom);
         hold = 1'($urandom_range(0, 1));
         do_req(1'($urandom_range(0, 1)), 32'(w * 4) | 32'($urandom_range(0, 3)), be, $urandom, hold, 1'b1);
         if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      req_valid = 1'b0;
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog");
   end
endmodule
